multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 177 +++++++++++++++++
 tb/tb_multicycle_control.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control: Moore FSM driving datapath selects/enables, retired-instruction counter.
// Latency FETCH-inclusive: lw 5, sw/R/addi 4, beq/j 3, illegal 2; no backpressure.
module multicycle_control #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_wire,
   input  logic                 rst_wire,
   input  logic [5:0]           opcode,
   input  logic [5:0]           FUNCT,
   input  logic                 zero,
   output logic                 IorD,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic                 RegDst,
   output logic                 MemtoReg,
   output logic                 RegWrite,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           PCSrc,
   output logic                 PCEn,
   output logic [2:0]           ALU_CONTROL,
   output logic [3:0]           state_out,
   output logic                 instr_done,
   output logic                 illegal_op,
   output logic [CNT_WIDTH-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t state, state_nxt;

   always_ff @(posedge clk_wire or posedge rst_wire) begin
      if (rst_wire) state <= S_FETCH;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt   = S_FETCH;
      IorD        = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSrc       = 2'b00;
      PCEn        = 1'b0;
      ALU_CONTROL = ALU_ADD;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;

      case (state)
         S_FETCH: begin
            IRWrite   = 1'b1;
            ALUSrcB   = 2'b01;
            PCEn      = 1'b1;
            state_nxt = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_RTYP:      state_nxt = S_EXECUTE;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_ADDI:      state_nxt = S_ADDIEXEC;
               OP_J:         state_nxt = S_JUMP;
               default: begin
                  illegal_op = 1'b1;
                  state_nxt  = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            IorD      = 1'b1;
            state_nxt = S_MEMWB;
         end
         S_MEMWB: begin
            MemtoReg   = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            IorD       = 1'b1;
            MemWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_EXECUTE: begin
            ALUSrcA   = 1'b1;
            state_nxt = S_ALUWB;
            case (FUNCT)
               6'b100010: ALU_CONTROL = ALU_SUB;
               6'b100100: ALU_CONTROL = ALU_AND;
               6'b100101: ALU_CONTROL = ALU_OR;
               6'b101010: ALU_CONTROL = ALU_SLT;
               default:   ALU_CONTROL = ALU_ADD;
            endcase
         end
         S_ALUWB: begin
            RegDst     = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALU_CONTROL = ALU_SUB;
            PCSrc       = 2'b01;
            PCEn        = zero;
            instr_done  = 1'b1;
         end
         S_ADDIEXEC: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            state_nxt = S_ADDIWB;
         end
         S_ADDIWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_JUMP: begin
            PCSrc      = 2'b10;
            PCEn       = 1'b1;
            instr_done = 1'b1;
         end
         default: state_nxt = S_FETCH;
      endcase

      // Reset holds FETCH selects but must not let any write or pulse escape.
      if (rst_wire) begin
         IRWrite    = 1'b0;
         PCEn       = 1'b0;
         MemWrite   = 1'b0;
         RegWrite   = 1'b0;
         instr_done = 1'b0;
         illegal_op = 1'b0;
      end
   end

   assign state_out = state;

   always_ff @(posedge clk_wire or posedge rst_wire) begin
      if (rst_wire)        instr_count <= '0;
      else if (instr_done) instr_count <= instr_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

   logic       clk_wire = 1'b0;
   logic       rst_wire = 1'b1;
   logic [5:0] opcode   = '0;
   logic [5:0] FUNCT    = '0;
   logic       zero     = 1'b0;

   // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSrc,PCEn,ALU,done,illegal}
   wire [16:0] dut_ctl;
   wire [3:0]  state_out;
   wire [15:0] cnt16;
   wire [16:0] c4_ctl;
   wire [3:0]  s4;
   wire [3:0]  cnt4;

   multicycle_control dut (
      .clk_wire(clk_wire), .rst_wire(rst_wire), .opcode(opcode), .FUNCT(FUNCT), .zero(zero),
      .IorD(dut_ctl[16]), .MemWrite(dut_ctl[15]), .IRWrite(dut_ctl[14]), .RegDst(dut_ctl[13]),
      .MemtoReg(dut_ctl[12]), .RegWrite(dut_ctl[11]), .ALUSrcA(dut_ctl[10]), .ALUSrcB(dut_ctl[9:8]),
      .PCSrc(dut_ctl[7:6]), .PCEn(dut_ctl[5]), .ALU_CONTROL(dut_ctl[4:2]), .state_out(state_out),
      .instr_done(dut_ctl[1]), .illegal_op(dut_ctl[0]), .instr_count(cnt16)
   );

   multicycle_control #(.CNT_WIDTH(4)) dut4 (
      .clk_wire(clk_wire), .rst_wire(rst_wire), .opcode(opcode), .FUNCT(FUNCT), .zero(zero),
      .IorD(c4_ctl[16]), .MemWrite(c4_ctl[15]), .IRWrite(c4_ctl[14]), .RegDst(c4_ctl[13]),
      .MemtoReg(c4_ctl[12]), .RegWrite(c4_ctl[11]), .ALUSrcA(c4_ctl[10]), .ALUSrcB(c4_ctl[9:8]),
      .PCSrc(c4_ctl[7:6]), .PCEn(c4_ctl[5]), .ALU_CONTROL(c4_ctl[4:2]), .state_out(s4),
      .instr_done(c4_ctl[1]), .illegal_op(c4_ctl[0]), .instr_count(cnt4)
   );

   always #5 clk_wire = ~clk_wire;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         model_cnt = 0;
   bit         chk_en    = 1'b0;
   logic [3:0]  exp_state;
   logic [16:0] exp_ctl;
   int          exp_cnt;
   logic [20:0] trace[$];

   function automatic logic [2:0] alu_for(input logic [5:0] fn);
      case (fn)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Datapath controls a given step must show (pulses excluded).
   function automatic logic [14:0] step_ctl(input int st, input logic [5:0] fn, input logic z);
      logic iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, pe = 0;
      logic [1:0] sb = 2'b00, ps = 2'b00;
      logic [2:0] alu = 3'b010;
      case (st)
         0:  begin irw = 1; sb = 2'b01; pe = 1; end
         1:  sb = 2'b11;
         2:  begin sa = 1; sb = 2'b10; end
         3:  iord = 1;
         4:  begin m2r = 1; rw = 1; end
         5:  begin iord = 1; mw = 1; end
         6:  begin sa = 1; alu = alu_for(fn); end
         7:  begin rd = 1; rw = 1; end
         8:  begin sa = 1; alu = 3'b110; ps = 2'b01; pe = z; end
         9:  begin sa = 1; sb = 2'b10; end
         10: rw = 1;
         11: begin ps = 2'b10; pe = 1; end
         default: ;
      endcase
      return {iord, mw, irw, rd, m2r, rw, sa, sb, ps, pe, alu};
   endfunction

   // zsel: 0/1 force zero, 2 random. nsteps>0 stops early (instruction left in flight).
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zsel, input int nsteps);
      int sq[$];
      bit legal = 1'b1;
      int n;
      case (op)
         6'b100011: sq = {0, 1, 2, 3, 4};
         6'b101011: sq = {0, 1, 2, 5};
         6'b000000: sq = {0, 1, 6, 7};
         6'b000100: sq = {0, 1, 8};
         6'b001000: sq = {0, 1, 9, 10};
         6'b000010: sq = {0, 1, 11};
         default: begin sq = {0, 1}; legal = 1'b0; end
      endcase
      n = (nsteps > 0 && nsteps < sq.size()) ? nsteps : sq.size();
      for (int i = 0; i < n; i++) begin
         opcode    = (sq[i] == 1 || sq[i] == 2) ? op : 6'($urandom);
         FUNCT     = (sq[i] == 6) ? fn : 6'($urandom);
         zero      = (zsel == 2) ? 1'($urandom) : zsel[0];
         exp_state = 4'(sq[i]);
         exp_ctl   = {step_ctl(sq[i], fn, zero), legal && (i == sq.size() - 1), !legal && (i == 1)};
         exp_cnt   = model_cnt;
         chk_en    = 1'b1;
         @(posedge clk_wire); #1;
         if (legal && i == sq.size() - 1) model_cnt++;
      end
      chk_en = 1'b0;
   endtask

   always @(negedge clk_wire) begin
      if (chk_en) begin
         chk("state", 32'(state_out), 32'(exp_state));
         chk("ctl", 32'(dut_ctl), 32'(exp_ctl));
         chk("cnt16", 32'(cnt16), exp_cnt & 32'hFFFF);
         chk("state4", 32'(s4), 32'(exp_state));
         chk("ctl4", 32'(c4_ctl), 32'(exp_ctl));
         chk("cnt4", 32'(cnt4), exp_cnt & 32'hF);
         trace.push_back({state_out, dut_ctl});
      end
   end

   // ---------------- stimulus ----------------
   logic [5:0] legal_ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
   logic [5:0] fn_tab    [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

   initial begin
      logic [19:0] st_word;
      logic [4:0]  wb_mask;
      logic [5:0]  op, fn;

      repeat (2) @(posedge clk_wire);
      #1;
      chk("rst_state", 32'(state_out), 32'h0);
      chk("rst_cnt", 32'(cnt16), 32'h0);
      chk("rst_ctl", 32'(dut_ctl), 32'h108);
      rst_wire = 1'b0;

      // lw: states 0,1,2,3,4 then back to 0; write-back only in state 4
      trace.delete();
      run_instr(6'b100011, 6'h00, 2, 0);
      chk("lw_len", 32'(trace.size()), 32'd5);
      st_word = '0;
      wb_mask = '0;
      for (int i = 0; i < 5 && i < trace.size(); i++) begin
         st_word = {st_word[15:0], trace[i][20:17]};
         wb_mask[i] = trace[i][11] & trace[i][12];
      end
      chk("lw_states", 32'(st_word), 32'h01234);
      chk("lw_wb_mask", 32'(wb_mask), 32'b10000);
      #3;
      chk("lw_back_fetch", 32'(state_out), 32'h0);
      chk("lw_count", 32'(cnt16), 32'd1);

      // illegal opcode: two cycles, pulse in DECODE, count unchanged
      trace.delete();
      run_instr(6'b111111, 6'h00, 2, 0);
      chk("ill_len", 32'(trace.size()), 32'd2);
      if (trace.size() == 2) chk("ill_pulse", 32'(trace[1][0]), 32'd1);
      chk("ill_count", 32'(cnt16), 32'd1);

      // R-type slt
      trace.delete();
      run_instr(6'b000000, 6'b101010, 2, 0);
      chk("slt_len", 32'(trace.size()), 32'd4);
      if (trace.size() == 4) begin
         chk("slt_alu", 32'(trace[2][4:2]), 32'd7);
         chk("slt_wb", 32'({trace[3][13], trace[3][11]}), 32'b11);
      end

      // beq taken then not taken, both retire
      trace.delete();
      run_instr(6'b000100, 6'h00, 1, 0);
      run_instr(6'b000100, 6'h00, 0, 0);
      chk("beq_len", 32'(trace.size()), 32'd6);
      if (trace.size() == 6) begin
         chk("beq1_pc", 32'({trace[2][7:6], trace[2][5]}), 32'b011);
         chk("beq0_pcen", 32'(trace[5][5]), 32'd0);
      end
      chk("beq_count", 32'(cnt16), 32'd4);

      // randomized mix
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 6) == 6) begin
            do op = 6'($urandom);
            while (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
         end else begin
            op = legal_ops[$urandom_range(0, 5)];
         end
         fn = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
         run_instr(op, fn, 2, 0);
      end

      // async reset while in MEMRD
      run_instr(6'b100011, 6'h00, 2, 3);
      chk("pre_rst_state", 32'(state_out), 32'd3);
      #2 rst_wire = 1'b1;
      #1;
      chk("arst_state", 32'(state_out), 32'h0);
      chk("arst_ctl", 32'(dut_ctl), 32'h108);
      chk("arst_cnt", 32'(cnt16), 32'h0);
      chk("arst_cnt4", 32'(cnt4), 32'h0);
      model_cnt = 0;
      @(posedge clk_wire); #1;
      chk("hold_rst_state", 32'(state_out), 32'h0);
      chk("hold_rst_ctl", 32'(dut_ctl), 32'h108);
      rst_wire = 1'b0;

      // 16 jumps: 4-bit counter wraps back to 0
      for (int k = 0; k < 15; k++) run_instr(6'b000010, 6'h00, 2, 0);
      chk("jmp15_cnt4", 32'(cnt4), 32'd15);
      run_instr(6'b000010, 6'h00, 2, 0);
      chk("jmp16_cnt4", 32'(cnt4), 32'd0);
      chk("jmp16_cnt16", 32'(cnt16), 32'd16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
